nes_clk_en_seq: RTL and testbench

Parametrised clock-enable and reset sequencer for the NES core, sitting between the PLL/BUFG outputs and the CPU/PPU/APU domains. It replaces per-domain divided clocks with single-clock enable strobes, configurable per channel in ratio and phase. It generalises the fixed 8-stage reset-stretch register into a lock-aware state machine with staggered per-channel reset release, pause control and a ready indication.

---
 rtl/nes_clk_pkg.sv | 23 ++
 rtl/clk_en_div.sv | 34 +++
 rtl/nes_clk_en_seq.sv | 116 +++++++++++
 tb/tb_nes_clk_en_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/nes_clk_pkg.sv
// Shared definitions for the NES clock-enable / reset sequencer.
// Holds the sequencer state encoding and the canonical NES divide ratios.
package nes_clk_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    // Master-clock divide ratios for the NES sub-domains.
    localparam int NES_DIV_PPU = 4;
    localparam int NES_DIV_CPU = 12;
    localparam int NES_DIV_APU = 24;

    localparam int NES_RST_STRETCH_DEF = 8;
    localparam int NES_RST_STAGGER_DEF = 4;

    // Stretch and stagger both fit in 1..255, so one 8-bit counter serves both.
    localparam int NES_SEQ_CNT_W = 8;

endpackage

// File: rtl/clk_en_div.sv
// One channel of the enable generator: a down-counter that strobes ce at zero.
// The counter freezes while paused, so strobes shift instead of being lost.
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [DIV_W-1:0] phase,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             pause,
    output logic             ce
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);
    // Ratios 0 and 1 both mean "every running cycle".
    assign reload   = (div > DIV_W'(1)) ? div - 1'b1 : '0;
    assign ce       = run & ~pause & cnt_zero;

    // NOTE: the counter has no reset of its own; it is reloaded from phase
    // whenever the channel is held in reset, which is also its reset state.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= phase;
        end else if (run && !pause) begin
            cnt <= cnt_zero ? reload : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nes_clk_en_seq.sv
// Clock-enable and reset sequencer: lock synchroniser, stretch/stagger FSM
// and one enable divider per channel, all on the single master clock.
module nes_clk_en_seq
    import nes_clk_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0] CH_DIV      = {8'(NES_DIV_CPU), 8'(NES_DIV_PPU)},
    parameter logic [NUM_CH*DIV_W-1:0] CH_PHASE    = {8'd0, 8'd0},
    parameter int                      RST_STRETCH = NES_RST_STRETCH_DEF,
    parameter int                      RST_STAGGER = NES_RST_STAGGER_DEF
) (
    input  logic              clk,
    input  logic              rstn_in,
    input  logic              lock_in,
    input  logic              pause_in,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready_out
);

    localparam int                   CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]      LAST_CH      = CH_W'(NUM_CH - 1);
    localparam logic [NES_SEQ_CNT_W-1:0] STRETCH_LAST = NES_SEQ_CNT_W'(RST_STRETCH - 1);
    localparam logic [NES_SEQ_CNT_W-1:0] STAGGER_LAST = NES_SEQ_CNT_W'(RST_STAGGER - 1);
    localparam bool_release_all = (RST_STAGGER == 0) || (NUM_CH == 1);

    logic                     lock_meta;
    logic                     lock_s;
    seq_state_e               state;
    logic [NES_SEQ_CNT_W-1:0] seq_cnt;
    logic [CH_W-1:0]          next_ch;
    logic [NUM_CH-1:0]        rst_q;
    logic                     ready_q;

    // NOTE: every sequential block uses non-blocking assignments so all
    // flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock_in;
            lock_s    <= lock_meta;
        end
    end

    // Loss of lock is treated exactly like a reset request.
    always_ff @(posedge clk) begin
        if (!rstn_in || !lock_s) begin
            state   <= ST_HOLD;
            seq_cnt <= '0;
            next_ch <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    state   <= ST_STRETCH;
                    seq_cnt <= '0;
                end
                ST_STRETCH: begin
                    if (seq_cnt == STRETCH_LAST) begin
                        seq_cnt  <= '0;
                        next_ch  <= CH_W'(1);
                        if (bool_release_all) begin
                            rst_q   <= '0;
                            ready_q <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            rst_q[0] <= 1'b0;
                            state    <= ST_RELEASE;
                        end
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Channel next_ch is released RST_STAGGER cycles after its predecessor.
                    if (seq_cnt == STAGGER_LAST) begin
                        seq_cnt        <= '0;
                        rst_q[next_ch] <= 1'b0;
                        next_ch        <= next_ch + 1'b1;
                        if (next_ch == LAST_CH) begin
                            ready_q <= 1'b1;
                            state   <= ST_RUN;
                        end
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign rst_out   = rst_q;
    assign ready_out = ready_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_div
        clk_en_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk  (clk),
            .load (rst_q[i]),
            .phase(CH_PHASE[i*DIV_W +: DIV_W]),
            .div  (CH_DIV[i*DIV_W +: DIV_W]),
            .run  (~rst_q[i]),
            .pause(pause_in),
            .ce   (ce_out[i])
        );
    end

endmodule

// File: tb/tb_nes_clk_en_seq.sv
// Scoreboard bench for nes_clk_en_seq: three configurations share one stimulus
// stream and are checked against a timeline model of the sequencing rules.
module tb_nes_clk_en_seq;

    logic clk = 1'b0;
    logic rstn_in = 1'b0;
    logic lock_in = 1'b0;
    logic pause_in = 1'b0;

    logic [1:0] ce_a, rst_a, ce_b, rst_b;
    logic [2:0] ce_c, rst_c;
    logic       rdy_a, rdy_b, rdy_c;

    always #5 clk = ~clk;

    // A: defaults. B: phases ch0=1, ch1=3. C: three channels, no stagger, ch2 ratio 1.
    nes_clk_en_seq u_a (
        .clk(clk), .rstn_in(rstn_in), .lock_in(lock_in), .pause_in(pause_in),
        .ce_out(ce_a), .rst_out(rst_a), .ready_out(rdy_a)
    );

    nes_clk_en_seq #(
        .CH_PHASE({8'd3, 8'd1})
    ) u_b (
        .clk(clk), .rstn_in(rstn_in), .lock_in(lock_in), .pause_in(pause_in),
        .ce_out(ce_b), .rst_out(rst_b), .ready_out(rdy_b)
    );

    nes_clk_en_seq #(
        .NUM_CH(3),
        .CH_DIV({8'd1, 8'd24, 8'd3}),
        .CH_PHASE({8'd0, 8'd5, 8'd2}),
        .RST_STAGGER(0)
    ) u_c (
        .clk(clk), .rstn_in(rstn_in), .lock_in(lock_in), .pause_in(pause_in),
        .ce_out(ce_c), .rst_out(rst_c), .ready_out(rdy_c)
    );

    typedef struct packed {
        logic [2:0][2:0] ce;
        logic [2:0][2:0] rst;
        logic [2:0]      rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference parameters per instance [inst][channel].
    int m_nch [3]    = '{2, 2, 3};
    int m_div [3][3] = '{'{4, 12, 1}, '{4, 12, 1}, '{3, 24, 1}};
    int m_ph  [3][3] = '{'{0, 0, 0}, '{1, 3, 0}, '{2, 5, 0}};
    int m_str [3]    = '{8, 8, 8};
    int m_stg [3]    = '{4, 4, 0};

    // Timeline model: m_streak counts consecutive edges with reset released and
    // lock synchronised; m_u counts unpaused running cycles since a channel's release.
    bit m_meta   = 1'b0;
    bit m_lock_s = 1'b0;
    int m_streak = 0;
    int m_u [3][3];

    function automatic bit released(int i, int k);
        return m_streak >= m_str[i] + k * m_stg[i] + 1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit good;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < m_nch[i]; k++)
                if (released(i, k) && !pause_in) m_u[i][k]++;
        good     = rstn_in && m_lock_s;
        m_lock_s = rstn_in ? m_meta : 1'b0;
        m_meta   = rstn_in ? lock_in : 1'b0;
        m_streak = good ? m_streak + 1 : 0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < m_nch[i]; k++)
                if (!released(i, k)) m_u[i][k] = 0;
    endtask

    task automatic step(input bit rstn_v, input bit lock_v, input bit pause_v);
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        model_edge();
        rstn_in  = rstn_v;
        lock_in  = lock_v;
        pause_in = pause_v;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            e.rdy[i] = 1'b1;
            for (int k = 0; k < m_nch[i]; k++) begin
                d = (m_div[i][k] < 1) ? 1 : m_div[i][k];
                if (released(i, k)) begin
                    e.ce[i][k] = !pause_v && (m_u[i][k] >= m_ph[i][k])
                                 && ((m_u[i][k] - m_ph[i][k]) % d == 0);
                end else begin
                    e.rst[i][k] = 1'b1;
                    e.rdy[i]    = 1'b0;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = '0;
            a.ce[0]  = {1'b0, ce_a};
            a.ce[1]  = {1'b0, ce_b};
            a.ce[2]  = ce_c;
            a.rst[0] = {1'b0, rst_a};
            a.rst[1] = {1'b0, rst_b};
            a.rst[2] = rst_c;
            a.rdy    = {rdy_c, rdy_b, rdy_a};
            for (int i = 0; i < 3; i++) begin
                check($sformatf("inst%0d ce_out", i), {5'd0, a.ce[i]}, {5'd0, e.ce[i]});
                check($sformatf("inst%0d rst_out", i), {5'd0, a.rst[i]}, {5'd0, e.rst[i]});
                check($sformatf("inst%0d ready_out", i), {7'd0, a.rdy[i]}, {7'd0, e.rdy[i]});
            end
        end
    end

    initial begin
        int lock_down = 0;
        int rst_down  = 0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                m_u[i][k] = 0;

        // Reset with and without lock present.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        // Full release sequence and free-running enables.
        repeat (40) step(1'b1, 1'b1, 1'b0);
        // Five-cycle pause in RUN.
        repeat (5) step(1'b1, 1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b1, 1'b0);
        // Lock loss in RUN, then relock.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b1, 1'b0);
        // Lock loss, relock, then a one-cycle reset pulse part-way through stretch.
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (40) step(1'b1, 1'b1, 1'b0);

        // Randomised pause, lock dropouts and reset pulses.
        repeat (3000) begin
            if (lock_down == 0 && $urandom_range(0, 299) == 0) lock_down = $urandom_range(1, 5);
            if (rst_down == 0 && $urandom_range(0, 249) == 0) rst_down = $urandom_range(1, 3);
            step(rst_down == 0, lock_down == 0, $urandom_range(0, 3) == 0);
            if (lock_down > 0) lock_down--;
            if (rst_down > 0) rst_down--;
        end
        repeat (20) step(1'b1, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
